tmds_encoder_8b10b: RTL and testbench
=====================================

Name: tmds_encoder_8b10b

Overview:
- One DVI TMDS channel encoder: 8-bit pixel data plus 2 control bits in, DC-balanced 10-bit symbol out.
- Three instances (B, G, R) sit directly downstream of the pixel-clock reset synchroniser.
- Its reset input is driven by that synchroniser's `syn_rst` output: asynchronous assert, release synchronous to `clk`.
- Output feeds the 10:1 serialiser.

Parameters:
- None. Coding is fixed by DVI 1.0 TMDS.

Ports:
- clk  input  1  pixel clock; all state on rising edge
- syn_rst  input  1  asynchronous, active-high reset (from reset synchroniser)
- din  input  8  pixel data byte, valid when de=1
- c0  input  1  control bit 0 (HSYNC on blue channel)
- c1  input  1  control bit 1 (VSYNC on blue channel)
- de  input  1  data enable: 1 = video period, 0 = control period
- q_out  output  10  TMDS symbol, registered; bit 0 is transmitted first

Behaviour:
- Reset: `syn_rst`=1 asynchronously clears all pipeline registers.
  - de pipe=0, control pipe=00, disparity counter cnt=0.
  - q_out=10'b1101010100 (0x354) immediately, not on the next edge.
  - After release, q_out stays 0x354 until valid de/c values propagate.
- Pipeline: 3 register stages, latency 3 clocks from input edge to q_out; one symbol per clock, no stalls.
  - S1 registers din, de, c1c0 and n1d = popcount(din) (4 bits).
  - S2 registers q_m[8:0], de, c1c0.
  - S3 registers q_out and updates cnt.
- Stage 2 transition-minimise rule:
  - If n1d>4, or n1d==4 and din[0]==0: q_m[0]=din[0], q_m[i]=~(q_m[i-1]^din[i]) for i=1..7, q_m[8]=0.
  - Otherwise: q_m[i]=q_m[i-1]^din[i], q_m[8]=1.
- Stage 3: N1/N0 = number of ones/zeros in q_m[7:0]. cnt is a 6-bit signed two's-complement value; DVI bounds keep |cnt|≤10, so no wrap.
- Stage 3, de=0 (control period): cnt<=0; q_out by {c1,c0}:
  - 00 -> 0x354
  - 01 -> 0x0AB
  - 10 -> 0x154
  - 11 -> 0x2AB
- Stage 3, de=1, case A (cnt==0 or N1==N0):
  - q_out={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
  - cnt += q_m[8] ? (N1-N0) : (N0-N1)
- Stage 3, de=1, case B ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)):
  - q_out={1, q_m[8], ~q_m[7:0]}
  - cnt += 2*q_m[8] + (N0-N1)
- Stage 3, de=1, case C (otherwise):
  - q_out={0, q_m[8], q_m[7:0]}
  - cnt += (N1-N0) - 2*(~q_m[8])
- Mid-stream de toggles: de and c1c0 are pipelined alongside data, so each symbol uses the de/c sampled with its own din. The first data symbol after a control period always starts from cnt=0.
- Reset mid-frame: all in-flight symbols are discarded and cnt=0. The first symbol after release is encoded from cnt=0.
- Inputs are sampled only on `clk`. No combinational path from any input to q_out.

Test Plan:
- Assert `syn_rst` between clock edges with din=0xA5, de=1 streaming -> q_out=0x354 immediately and held through reset. After release, first data symbol appears exactly 3 clocks after its input edge.
- From reset, de=0 with {c1,c0}=00, 01, 10, 11 on consecutive clocks -> q_out=0x354, 0x0AB, 0x154, 0x2AB starting 3 clocks later. cnt stays 0.
- de=1, din=0x00 three cycles from cnt=0 -> q_out=0x100, 0x3FF, 0x100, with internal cnt=-8, +2, -6.
- de=1, din=0xFF once from cnt=0 -> XNOR path, q_m=0x0FF, q_out=0x200, cnt=-8.
- Long random de=1 stream vs golden DVI reference model -> bit-exact q_out. |cnt|≤10 always. Running bit disparity of q_out bounded.
- Data burst, de=0 for 1 clock, then data burst -> control token in exact slot and cnt reset to 0. Second burst matches the model started from cnt=0.

Source files
------------

// File: rtl/tmds_encoder_8b10b.sv
// DVI TMDS channel encoder: 8b data + 2 control bits to DC-balanced 10b symbol, latency 3 clk.
// No backpressure: accepts and emits one symbol every clock, never stalls.
module tmds_encoder_8b10b (
    input  logic       clk,
    input  logic       syn_rst,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] q_out
);

    localparam logic [9:0] CTL_00 = 10'h354;
    localparam logic [9:0] CTL_01 = 10'h0AB;
    localparam logic [9:0] CTL_10 = 10'h154;
    localparam logic [9:0] CTL_11 = 10'h2AB;

    // Stage 1: input capture and data popcount
    logic [7:0] din_d, din_q;
    logic       de1_d, de1_q;
    logic [1:0] ctl1_d, ctl1_q;
    logic [3:0] n1d_d, n1d_q;

    always_comb begin
        din_d  = din;
        de1_d  = de;
        ctl1_d = {c1, c0};
        n1d_d  = '0;
        for (int i = 0; i < 8; i++) begin
            n1d_d = n1d_d + {3'b000, din[i]};
        end
    end

    // Stage 2: transition-minimised word q_m
    logic       use_xnor;
    logic [8:0] qm_d, qm_q;
    logic       de2_d, de2_q;
    logic [1:0] ctl2_d, ctl2_q;

    always_comb begin
        use_xnor = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && !din_q[0]);
        qm_d     = '0;
        qm_d[0]  = din_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din_q[i]) : (qm_d[i-1] ^ din_q[i]);
        end
        qm_d[8] = ~use_xnor;
        de2_d   = de1_q;
        ctl2_d  = ctl1_q;
    end

    // Stage 3: DC balancing against the running disparity cnt
    logic [3:0]        n1_s3;
    logic signed [5:0] diff;
    logic signed [5:0] cnt_d, cnt_q;
    logic [9:0]        q_out_d, q_out_q;

    always_comb begin
        n1_s3 = '0;
        for (int i = 0; i < 8; i++) begin
            n1_s3 = n1_s3 + {3'b000, qm_q[i]};
        end
        // N1 - N0 = 2*N1 - 8
        diff    = $signed({1'b0, n1_s3, 1'b0}) - 6'sd8;
        q_out_d = CTL_00;
        cnt_d   = cnt_q;
        if (!de2_q) begin
            cnt_d = '0;
            case (ctl2_q)
                2'b00:   q_out_d = CTL_00;
                2'b01:   q_out_d = CTL_01;
                2'b10:   q_out_d = CTL_10;
                default: q_out_d = CTL_11;
            endcase
        end else if ((cnt_q == 6'sd0) || (n1_s3 == 4'd4)) begin
            q_out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d   = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((!cnt_q[5] && (n1_s3 > 4'd4)) || (cnt_q[5] && (n1_s3 < 4'd4))) begin
            q_out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d   = cnt_q - diff + (qm_q[8] ? 6'sd2 : 6'sd0);
        end else begin
            q_out_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d   = cnt_q + diff - (qm_q[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk or posedge syn_rst) begin
        if (syn_rst) begin
            din_q   <= '0;
            de1_q   <= 1'b0;
            ctl1_q  <= 2'b00;
            n1d_q   <= '0;
            qm_q    <= '0;
            de2_q   <= 1'b0;
            ctl2_q  <= 2'b00;
            q_out_q <= CTL_00;
            cnt_q   <= '0;
        end else begin
            din_q   <= din_d;
            de1_q   <= de1_d;
            ctl1_q  <= ctl1_d;
            n1d_q   <= n1d_d;
            qm_q    <= qm_d;
            de2_q   <= de2_d;
            ctl2_q  <= ctl2_d;
            q_out_q <= q_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_out = q_out_q;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Bench for the TMDS channel encoder: directed steps with a scoreboard of expected symbols.
module tb_tmds_encoder_8b10b;

    logic       clk = 1'b0;
    logic       syn_rst;
    logic [7:0] din;
    logic       c0;
    logic       c1;
    logic       de;
    logic [9:0] q_out;

    tmds_encoder_8b10b dut (
        .clk    (clk),
        .syn_rst(syn_rst),
        .din    (din),
        .c0     (c0),
        .c1     (c1),
        .de     (de),
        .q_out  (q_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]        sym;
        logic signed [5:0] cnt;
        int                due;
        bit                isdata;
        string             tag;
    } entry_t;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     mcnt   = 0;
    int     rd     = 0;

    // Reference DVI 1.0 TMDS encoder with its own disparity state
    task automatic model(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                         output logic [9:0] sym);
        int         ones;
        int         zeros;
        bit         xn;
        logic [8:0] qm;
        if (!d_e) begin
            mcnt = 0;
            case (c)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else begin
            ones  = $countones(d);
            xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !xn;
            ones  = $countones(qm[7:0]);
            zeros = 8 - ones;
            if (mcnt == 0 || ones == zeros) begin
                sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                mcnt = mcnt + (qm[8] ? (ones - zeros) : (zeros - ones));
            end else if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
                sym  = {1'b1, qm[8], ~qm[7:0]};
                mcnt = mcnt + 2 * int'(qm[8]) + zeros - ones;
            end else begin
                sym  = {1'b0, qm[8], qm[7:0]};
                mcnt = mcnt + ones - zeros - 2 * int'(!qm[8]);
            end
        end
    endtask

    task automatic chk_sym(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s q_out: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic signed [5:0] obs, input logic signed [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cnt: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        entry_t e;
        int     ones;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk_sym(e.tag, q_out, e.sym);
            chk_cnt(e.tag, dut.cnt_q, e.cnt);
            if (e.isdata) begin
                ones = $countones(q_out);
                rd   = rd + ones - (10 - ones);
                checks++;
                assert (rd >= -10 && rd <= 10) else begin
                    errors++;
                    $error("FAIL %s disparity: observed %0d expected within +/-10", e.tag, rd);
                end
            end else begin
                rd = 0;
            end
        end
    endtask

    task automatic push_drive(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                              input logic [9:0] sym, input logic signed [5:0] cnt, input string tag);
        entry_t e;
        de  = d_e;
        c0  = c[0];
        c1  = c[1];
        din = d;
        e.sym    = sym;
        e.cnt    = cnt;
        e.due    = cyc + 3;
        e.isdata = d_e;
        e.tag    = tag;
        sb.push_back(e);
        tick();
    endtask

    task automatic step(input logic d_e, input logic [1:0] c, input logic [7:0] d, input string tag);
        logic [9:0] sym;
        model(d_e, c, d, sym);
        push_drive(d_e, c, d, sym, 6'(mcnt), tag);
    endtask

    // Pinned literal expectation; the model still advances to stay in step
    task automatic step_lit(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                            input logic [9:0] lit, input logic signed [5:0] lit_cnt, input string tag);
        logic [9:0] sym;
        model(d_e, c, d, sym);
        push_drive(d_e, c, d, lit, lit_cnt, tag);
    endtask

    task automatic push_idle_after_reset();
        entry_t e;
        for (int k = 1; k <= 2; k++) begin
            e.sym    = 10'h354;
            e.cnt    = 6'sd0;
            e.due    = cyc + k;
            e.isdata = 1'b0;
            e.tag    = "post_rst_idle";
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [7:0] r;
        syn_rst = 1'b0;
        de      = 1'b1;
        c0      = 1'b0;
        c1      = 1'b0;
        din     = 8'hA5;

        // Power-on reset: output must be the idle token before any clock edge
        #1 syn_rst = 1'b1;
        #1;
        chk_sym("por_immediate", q_out, 10'h354);
        chk_cnt("por_immediate", dut.cnt_q, 6'sd0);
        repeat (2) begin
            tick();
            chk_sym("por_hold", q_out, 10'h354);
        end
        syn_rst = 1'b0;
        push_idle_after_reset();

        step_lit(1'b0, 2'b00, 8'h00, 10'h354, 6'sd0, "ctl00");
        step_lit(1'b0, 2'b01, 8'h00, 10'h0AB, 6'sd0, "ctl01");
        step_lit(1'b0, 2'b10, 8'h00, 10'h154, 6'sd0, "ctl10");
        step_lit(1'b0, 2'b11, 8'h00, 10'h2AB, 6'sd0, "ctl11");

        step_lit(1'b1, 2'b00, 8'h00, 10'h100, -6'sd8, "zero_a");
        step_lit(1'b1, 2'b00, 8'h00, 10'h3FF,  6'sd2, "zero_b");
        step_lit(1'b1, 2'b00, 8'h00, 10'h100, -6'sd6, "zero_c");
        step_lit(1'b0, 2'b00, 8'h00, 10'h354,  6'sd0, "ctl_gap");
        step_lit(1'b1, 2'b00, 8'hFF, 10'h200, -6'sd8, "ff_xnor");
        step_lit(1'b0, 2'b00, 8'h00, 10'h354,  6'sd0, "ctl_gap2");

        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom());
            step(1'b1, 2'b00, r, "rand");
        end

        for (int k = 0; k < 20; k++) begin
            r = 8'($urandom());
            step(1'b1, 2'b00, r, "burst1");
        end
        step_lit(1'b0, 2'b01, 8'h00, 10'h0AB, 6'sd0, "burst_gap");
        for (int k = 0; k < 20; k++) begin
            r = 8'($urandom());
            step(1'b1, 2'b00, r, "burst2");
        end

        // Mid-frame reset while 0xA5 streams with de=1
        for (int k = 0; k < 6; k++) step(1'b1, 2'b00, 8'hA5, "a5_pre");
        #2 syn_rst = 1'b1;
        sb.delete();
        mcnt = 0;
        rd   = 0;
        #1;
        chk_sym("rst_mid_immediate", q_out, 10'h354);
        chk_cnt("rst_mid_immediate", dut.cnt_q, 6'sd0);
        repeat (2) begin
            tick();
            chk_sym("rst_mid_hold", q_out, 10'h354);
        end
        syn_rst = 1'b0;
        push_idle_after_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 2'b00, 8'hA5, "a5_post");
        step_lit(1'b0, 2'b10, 8'h00, 10'h154, 6'sd0, "tail_ctl");

        de = 1'b0;
        c0 = 1'b0;
        c1 = 1'b0;
        for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
